// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes
// driven by the pipeline controller and the FSM state encoding.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/mul_div_unit_md_datapath.sv
// Shared 2*WIDTH shift register: shift-add multiply (multiplier in the low half)
// or restoring divide (remainder in the high half, quotient shifting into the low half).
module md_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   low_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic               sub_ok;
  logic [WIDTH-1:0]   sub_lo;

  assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign shifted = acc_q[2*WIDTH-1:WIDTH-1];
  assign sub_ok  = (shifted >= {1'b0, opb_q});
  // When the subtraction succeeds the difference is below the divisor, so W bits hold it.
  assign sub_lo  = shifted[WIDTH-1:0] - opb_q;

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    if (load_i) begin
      acc_d = {{WIDTH{1'b0}}, low_i};
      opb_d = opb_i;
    end else if (step_i) begin
      if (is_div_i) begin
        if (sub_ok) acc_d = {sub_lo, acc_q[WIDTH-2:0], 1'b1};
        else        acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {add_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Operates on magnitudes and
// fixes signs in a single FIX cycle; Busy lets the controller stall.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       mdop_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output md_state_e        state_o
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, neg_q, rem_neg_q, div0_q;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               accept, load, step, fix_wr, mt_hi, mt_lo;
  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   quot, rem;

  assign accept    = start_i && !abort_i && (mdop_i inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
  assign is_signed = (mdop_i == MD_MULT) || (mdop_i == MD_DIV);
  assign a_neg     = is_signed && a_i[WIDTH-1];
  assign b_neg     = is_signed && b_i[WIDTH-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= MD_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; abort wins over everything, including a new Start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept) state_d = MD_RUN;
      MD_RUN:  if (abort_i) state_d = MD_IDLE;
               else if (cnt_q == CNT_W'(WIDTH-1)) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_o = (state_q != MD_IDLE);
    load   = (state_q == MD_IDLE) && accept;
    step   = (state_q == MD_RUN);
    fix_wr = (state_q == MD_FIX) && !abort_i;
    mt_hi  = (state_q == MD_IDLE) && start_i && !abort_i && (mdop_i == MD_MTHI);
    mt_lo  = (state_q == MD_IDLE) && start_i && !abort_i && (mdop_i == MD_MTLO);
  end

  md_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (load),
    .step_i   (step),
    .is_div_i (is_div_q),
    .low_i    (mdop_i[1] ? a_mag : b_mag),
    .opb_i    (mdop_i[1] ? b_mag : a_mag),
    .acc_o    (acc)
  );

  assign rem  = acc[2*WIDTH-1:WIDTH];
  assign quot = acc[WIDTH-1:0];

  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (load) cnt_d = '0;
    else if (step) cnt_d = cnt_q + 1'b1;
    if (mt_hi) hi_d = a_i;
    if (mt_lo) lo_d = a_i;
    if (fix_wr) begin
      done_d = 1'b1;
      if (is_div_q) begin
        // Divide by zero: the divide loop already leaves |A| as remainder.
        lo_d = div0_q ? '1 : (neg_q ? -quot : quot);
        hi_d = rem_neg_q ? -rem : rem;
      end else begin
        {hi_d, lo_d} = neg_q ? -acc : acc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      if (load) begin
        is_div_q  <= mdop_i[1];
        neg_q     <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
        div0_q    <= (b_i == '0);
      end
    end
  end

  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign state_o = state_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit owning the HI/LO registers, beside the single-cycle ALU in the execute stage.
- Responds to issue requests from the pipeline controller, which is the initiator: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Exposes HI/LO for MFHI/MFLO, plus Busy/Done so the controller can stall.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  issue request; accepted only when Busy=0.
- MDop  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 reserved.
- A  input  WIDTH  rs operand (multiplicand / dividend / MT source).
- B  input  WIDTH  rt operand (multiplier / divisor).
- Abort  input  1  pipeline flush; cancels an in-flight operation.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when HI/LO have just been written by a MULT/DIV.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - State=IDLE; HI=0, LO=0, Busy=0, Done=0; counter=0.
  - Reset takes effect mid-operation and discards any partial result.
- States: IDLE, RUN, FIX.
  - Busy = (state != IDLE), driven combinationally from the state register.
  - Done is registered.
- IDLE:
  - Start=1 with MDop 0-3: latch operands. For signed ops, latch the absolute values and record the result signs. Counter=0, go to RUN.
  - Start=1 with MDop 4: HI<=A at the edge. MDop 5: LO<=A at the edge. Stay in IDLE, Busy stays 0, no Done.
  - MDop 6/7: ignored.
- RUN: one iteration per cycle, exactly WIDTH cycles; counter increments and leaves at WIDTH-1.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
- FIX (one cycle):
  - Apply sign correction.
  - Write HI/LO. Multiply: {HI,LO}=product. Divide: LO=quotient, HI=remainder.
  - Return to IDLE. Done=1 during the cycle after the FIX edge.
- Latency: Start accepted at edge N → HI/LO valid and Done=1 after edge N+WIDTH+1 (N+33 for the defaults). Busy is high for cycles N+1 through N+33.
- Back-to-back issue: Start is accepted in the same cycle Done is high, because the state is already IDLE.
- Start while Busy=1: ignored, with no queueing. The controller must hold the instruction.
- Abort=1 in RUN or FIX: go to IDLE at the next edge; HI/LO unchanged; no Done pulse.
  - Abort in IDLE takes priority over Start; nothing is accepted that cycle.
- Signed rules:
  - MULT product is the two's-complement of the magnitude product when the operand signs differ.
  - DIV quotient truncates toward zero; the remainder takes the sign of the dividend.
- Boundary results:
  - Divide by zero (DIV or DIVU): LO=all ones, HI=A. No exception; full latency still applies.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - MULTU 0xFFFFFFFF*0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
- HI/LO readback: HI/LO are read directly by MFHI/MFLO and hold their old values while Busy. The controller stalls MFHI/MFLO while Busy=1.

Decomposition:
- Shared package/header (alongside the ALU op constants):
  - MDop encodings (MD_MULT..MD_MTLO).
  - State encodings (MD_IDLE, MD_RUN, MD_FIX).
- One natural sub-module, md_datapath. It holds the accumulator and remainder/quotient shift registers and the add/subtract. The top level holds the FSM, counter, sign handling and HI/LO.

Test Plan:
- MULTU A=7, B=6 → Busy high 33 cycles; Done pulse; HI=0, LO=42.
- MULT A=-3 (0xFFFFFFFD), B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV A=-7, B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=100, B=7 → LO=14, HI=2.
- DIVU A=1234, B=0 → LO=0xFFFFFFFF, HI=1234. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI A=0xDEADBEEF, then MTLO A=0x12345678 → HI/LO updated the next edge with Busy=0. Then start MULTU 0xFFFFFFFF*0xFFFFFFFF, assert Abort at cycle 10 → IDLE, HI/LO still 0xDEADBEEF/0x12345678, no Done.
- Reset_n low mid-RUN, asynchronous and off-edge → Busy=0, HI=LO=0 immediately. Start during Busy → ignored, and the first operation's result is unchanged.
